pu_msp430_trace_buffer: RTL and testbench

Execution trace recorder for one MSP430 core, fed by the same core-internal probes as the testbench debug monitor (`decode`, `ir`, `pc`, `irq_detect`, `irq_num`) and sitting directly downstream of that decode point. On every instruction boundary it closes the previous instruction into a record and pushes the record into a FIFO. A record holds PC, opcode, IRQ flag and number, and measured cycle count. The bench drains the FIFO through a valid/ready port. The block also provides PC-match triggering with post-trigger capture and overflow accounting.

---
 rtl/pu_msp430_trace_buffer.sv | 204 ++++++++++++++++++++
 tb/tb_pu_msp430_trace_buffer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pu_msp430_trace_buffer.sv
// MSP430 execution trace recorder: closes each instruction into a record at the next
// decode boundary and queues it in a FIFO with PC-match triggering and drop accounting.
module pu_msp430_trace_buffer #(
    parameter int DEPTH    = 16,
    parameter int CYC_W    = 8,
    parameter int POST_CNT = 4
) (
    input  logic                      mclk,
    input  logic                      puc_rst,
    input  logic                      decode,
    input  logic [15:0]               ir,
    input  logic [15:0]               pc,
    input  logic                      irq_detect,
    input  logic [3:0]                irq_num,
    input  logic                      trace_en,
    input  logic                      trig_en,
    input  logic [15:0]               trig_pc,
    input  logic                      clr,
    input  logic                      rd_ready,
    output logic                      rd_valid,
    output logic [36+CYC_W:0]         rd_data,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic [7:0]                drop_cnt,
    output logic                      triggered
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = 37 + CYC_W;
    localparam int PW = $clog2(POST_CNT + 1) + 1;
    localparam logic [CYC_W-1:0] CNT_MAX  = {CYC_W{1'b1}};
    localparam logic [AW:0]      FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [PW-1:0]    POST_LIM = PW'(POST_CNT);

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_POST    = 2'd1,
        ST_STOPPED = 2'd2
    } state_t;

    logic [15:0]      cur_pc_q, cur_pc_d, cur_op_q, cur_op_d;
    logic             cur_irq_q, cur_irq_d, have_prev_q, have_prev_d;
    logic [3:0]       cur_irq_num_q, cur_irq_num_d;
    logic [CYC_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    state_t           state_q, state_d;
    logic [PW-1:0]    post_q, post_d, post_inc_s;
    logic [RW-1:0]    mem_q [DEPTH];

    logic          qual_s, accept_s, push_s, pop_s, drop_s, empty_s;
    logic [RW-1:0] cand_rec_s;

    assign empty_s    = (level_q == '0);
    assign cand_rec_s = {cur_irq_q, cur_irq_num_q, cnt_q, cur_op_q, cur_pc_q};
    assign qual_s     = decode && have_prev_q && trace_en && (state_q != ST_STOPPED);
    assign pop_s      = !empty_s && rd_ready && !clr;
    // A full FIFO still accepts when the head leaves on the same edge
    assign accept_s   = qual_s && ((level_q != FULL_LVL) || (!empty_s && rd_ready));
    assign push_s     = accept_s && !clr;
    assign drop_s     = qual_s && !accept_s && !clr;
    assign post_inc_s = post_q + PW'(1);

    // Next-state computation for instruction latch, FIFO bookkeeping and trigger FSM
    always_comb begin
        cur_pc_d      = cur_pc_q;
        cur_op_d      = cur_op_q;
        cur_irq_d     = cur_irq_q;
        cur_irq_num_d = cur_irq_num_q;
        have_prev_d   = have_prev_q;
        cnt_d         = cnt_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        overflow_d    = overflow_q;
        drop_cnt_d    = drop_cnt_q;
        state_d       = state_q;
        post_d        = post_q;

        if (decode) begin
            cur_pc_d      = pc;
            cur_op_d      = ir;
            cur_irq_d     = irq_detect;
            cur_irq_num_d = irq_num;
            have_prev_d   = 1'b1;
            cnt_d         = CYC_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CYC_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        // Flush wins over any same-cycle push/pop; the cycle counter keeps running
        if (clr) begin
            have_prev_d = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            drop_cnt_d  = 8'd0;
            state_d     = ST_ARMED;
            post_d      = '0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s && !pop_s) begin
                level_d = level_q + (AW + 1)'(1);
            end else if (pop_s && !push_s) begin
                level_d = level_q - (AW + 1)'(1);
            end else begin
                level_d = level_q;
            end
            if (drop_s) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end else begin
                    drop_cnt_d = drop_cnt_q;
                end
            end else begin
                overflow_d = overflow_q;
            end

            case (state_q)
                ST_ARMED: begin
                    if (push_s && trig_en && (cur_pc_q == trig_pc)) begin
                        post_d  = '0;
                        state_d = (POST_CNT == 0) ? ST_STOPPED : ST_POST;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_POST: begin
                    if (push_s) begin
                        post_d  = post_inc_s;
                        state_d = (post_inc_s == POST_LIM) ? ST_STOPPED : ST_POST;
                    end else begin
                        state_d = ST_POST;
                    end
                end
                ST_STOPPED: state_d = ST_STOPPED;
                default:    state_d = ST_ARMED;
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            cur_pc_q      <= 16'd0;
            cur_op_q      <= 16'd0;
            cur_irq_q     <= 1'b0;
            cur_irq_num_q <= 4'd0;
            have_prev_q   <= 1'b0;
            cnt_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            overflow_q    <= 1'b0;
            drop_cnt_q    <= 8'd0;
            state_q       <= ST_ARMED;
            post_q        <= '0;
        end else begin
            cur_pc_q      <= cur_pc_d;
            cur_op_q      <= cur_op_d;
            cur_irq_q     <= cur_irq_d;
            cur_irq_num_q <= cur_irq_num_d;
            have_prev_q   <= have_prev_d;
            cnt_q         <= cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            overflow_q    <= overflow_d;
            drop_cnt_q    <= drop_cnt_d;
            state_q       <= state_d;
            post_q        <= post_d;
        end
    end

    // Record storage; contents are don't-care until written, the read port is gated when empty
    always_ff @(posedge mclk) begin
        if (push_s && !puc_rst) begin
            mem_q[wr_ptr_q] <= cand_rec_s;
        end
    end

    assign rd_valid  = !empty_s;
    assign rd_data   = empty_s ? '0 : mem_q[rd_ptr_q];
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;
    assign triggered = (state_q != ST_ARMED);

endmodule

// File: tb/tb_pu_msp430_trace_buffer.sv
// Directed bench for pu_msp430_trace_buffer: records predicted from the stimulus timing
// are queued in a scoreboard and compared as the FIFO is drained.
module tb_pu_msp430_trace_buffer;

    logic        mclk = 1'b0;
    logic        puc_rst = 1'b1;
    logic        decode = 1'b0;
    logic [15:0] ir = 16'd0;
    logic [15:0] pc = 16'd0;
    logic        irq_detect = 1'b0;
    logic [3:0]  irq_num = 4'd0;
    logic        trace_en = 1'b0;
    logic        trig_en = 1'b0;
    logic [15:0] trig_pc = 16'd0;
    logic        clr = 1'b0;
    logic        rd_ready = 1'b0;
    logic        rd_valid;
    logic [44:0] rd_data;
    logic [4:0]  level;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        triggered;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic [44:0] sb[$];
    bit          has_prev = 1'b0;
    logic [15:0] p_pc, p_op;
    bit          p_irq;
    logic [3:0]  p_num;
    int          p_cyc;

    pu_msp430_trace_buffer #(.DEPTH(16), .CYC_W(8), .POST_CNT(4)) dut (
        .mclk(mclk), .puc_rst(puc_rst), .decode(decode), .ir(ir), .pc(pc),
        .irq_detect(irq_detect), .irq_num(irq_num), .trace_en(trace_en),
        .trig_en(trig_en), .trig_pc(trig_pc), .clr(clr), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .level(level), .overflow(overflow),
        .drop_cnt(drop_cnt), .triggered(triggered)
    );

    always #5 mclk = ~mclk;
    always @(posedge mclk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge mclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [44:0] mk_rec(input logic [15:0] a, input logic [15:0] op,
                                           input bit irq, input logic [3:0] num, input int len);
        logic [7:0] c;
        c = (len > 255) ? 8'hFF : len[7:0];
        return {irq, num, c, op, a};
    endfunction

    // One decode cycle followed by gap-1 idle cycles; predicts the record it closes
    task automatic dec(input logic [15:0] a, input bit irq, input logic [3:0] num,
                       input bit exp_push, input bit pop_too, input int gap);
        logic [15:0] op;
        op = a ^ 16'h5A5A;
        decode = 1'b1; pc = a; ir = op; irq_detect = irq; irq_num = num;
        if (pop_too) begin
            chk("pop_valid", rd_valid, 1);
            chk("pop_data", rd_data, sb.pop_front());
            rd_ready = 1'b1;
        end
        if (has_prev && exp_push) sb.push_back(mk_rec(p_pc, p_op, p_irq, p_num, cyc - p_cyc));
        has_prev = 1'b1; p_pc = a; p_op = op; p_irq = irq; p_num = num; p_cyc = cyc;
        tick;
        decode = 1'b0; irq_detect = 1'b0; rd_ready = 1'b0;
        repeat (gap - 1) tick;
    endtask

    task automatic drain(input int n);
        rd_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk("drain_valid", rd_valid, 1);
            chk("drain_data", rd_data, sb.pop_front());
            tick;
        end
        rd_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        tick; tick;
        puc_rst = 1'b0;
        chk("rst_valid", rd_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_trig", triggered, 0);
        chk("rst_data", rd_data, 0);
        trace_en = 1'b1;

        // Basic records and cycle lengths
        dec(16'hF000, 0, 4'h0, 1, 0, 2);
        chk("first_no_rec", level, 0);
        dec(16'hF002, 0, 4'h0, 1, 0, 3);
        dec(16'hF006, 0, 4'h0, 1, 0, 1);
        chk("two_level", level, 2);
        chk("rec0_pc", rd_data[15:0], 16'hF000);
        chk("rec0_cyc", rd_data[39:32], 8'd2);
        drain(2);
        chk("empty_level", level, 0);

        // Fill, overflow, then simultaneous push/pop while full
        for (int i = 0; i < 17; i++) dec(16'hF100 + 16'(2 * i), 0, 4'h0, i < 16, 0, 1);
        chk("full_level", level, 16);
        chk("full_ovf", overflow, 1);
        chk("full_drop", drop_cnt, 1);
        dec(16'hF200, 0, 4'h0, 1, 1, 1);
        chk("pp_level", level, 16);
        chk("pp_drop", drop_cnt, 1);
        drain(16);
        chk("ovf_sticky", overflow, 1);

        // Flush then trigger with post-capture
        clr = 1'b1; tick; clr = 1'b0;
        sb.delete(); has_prev = 1'b0;
        chk("clr_level", level, 0);
        chk("clr_ovf", overflow, 0);
        chk("clr_drop", drop_cnt, 0);
        trig_en = 1'b1; trig_pc = 16'hF010;
        for (int k = 0; k < 10; k++) begin
            dec(16'hF00C + 16'(2 * k), 0, 4'h0, (k >= 1) && (k <= 7), 0, 1);
            if (k == 2) chk("pre_trig", triggered, 0);
            if (k == 3) chk("post_trig", triggered, 1);
        end
        chk("trig_level", level, 7);
        chk("trig_drop", drop_cnt, 0);
        drain(7);
        dec(16'hF020, 0, 4'h0, 0, 0, 1);
        chk("stopped_level", level, 0);
        chk("stopped_trig", triggered, 1);
        clr = 1'b1; trig_en = 1'b0; tick; clr = 1'b0;
        has_prev = 1'b0;
        chk("clr2_trig", triggered, 0);
        dec(16'hF030, 0, 4'h0, 1, 0, 1);
        chk("resume_none", level, 0);
        dec(16'hF032, 0, 4'h0, 1, 0, 1);
        chk("resume_one", level, 1);
        drain(1);

        // Saturated cycle count, IRQ fields, trace_en gating
        dec(16'hF040, 1, 4'hE, 1, 0, 300);
        dec(16'hF042, 0, 4'h0, 1, 0, 1);
        trace_en = 1'b0;
        dec(16'hF044, 0, 4'h0, 0, 0, 1);
        trace_en = 1'b1;
        dec(16'hF046, 0, 4'h0, 1, 0, 1);
        chk("te_level", level, 3);
        chk("te_drop", drop_cnt, 0);
        drain(1);
        chk("irq_flag", rd_data[44], 1);
        chk("irq_num", rd_data[43:40], 4'hE);
        chk("sat_cyc", rd_data[39:32], 8'hFF);
        drain(2);

        // Reset mid-drain
        for (int k = 0; k < 8; k++) dec(16'hF060 + 16'(2 * k), 0, 4'h0, 1, 0, 1);
        drain(3);
        chk("mid_level", level, 5);
        puc_rst = 1'b1; rd_ready = 1'b1; tick;
        puc_rst = 1'b0; rd_ready = 1'b0;
        sb.delete(); has_prev = 1'b0;
        chk("prst_valid", rd_valid, 0);
        chk("prst_level", level, 0);
        chk("prst_trig", triggered, 0);
        chk("prst_data", rd_data, 0);
        dec(16'hF080, 0, 4'h0, 1, 0, 2);
        chk("prst_first", level, 0);
        dec(16'hF082, 0, 4'h0, 1, 0, 1);
        chk("prst_second", level, 1);
        drain(1);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
